// File: rtl/axi_sdram_pkg.sv
// Shared definitions for the AXI-to-SDRAM address path.
//   - AXI burst type encodings
//   - Bit-field offsets of a packed address request, relative to the top of
//     the address field: {axsize, axprot, axlock, axlen, axcache, axburst, axaddr}
//   - Boundary-splitter FSM states
//   - Helper that turns an AXI axlen into a beat count
package axi_sdram_pkg;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  // Offsets are added to ADDR_WIDTH; axaddr occupies [ADDR_WIDTH-1:0].
  localparam int REQ_BURST_LSB = 0;
  localparam int REQ_CACHE_LSB = 2;
  localparam int REQ_LEN_LSB   = 6;
  localparam int REQ_LOCK_LSB  = 14;
  localparam int REQ_PROT_LSB  = 15;
  localparam int REQ_SIZE_LSB  = 18;
  localparam int REQ_EXTRA_W   = 21;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_CALC  = 2'd1,
    ST_ISSUE = 2'd2
  } state_t;

  // axlen + 1, widened so that a 256-beat burst is representable.
  function automatic logic [8:0] beats_of(input logic [7:0] axlen);
    return {1'b0, axlen} + 9'd1;
  endfunction

endpackage

// File: rtl/axi_piece_calc.sv
// Combinational sub-burst calculator.
// Given the current address, the beats still to issue, the effective beat
// size and the burst type, produces the length of the next piece so that it
// stops at (never crosses) the next BOUNDARY_BYTES-aligned address.
// Ports:
//   cur_addr   in   ADDR_WIDTH  start address of this piece
//   remaining  in   9           beats still to issue (1..256)
//   sz         in   3           log2 of bytes per beat
//   burst      in   2           AXI burst type; only INCR is split
//   axlen      out  8           piece beats - 1
//   next_addr  out  ADDR_WIDTH  start of the following piece (boundary aligned)
//   last_piece out  1           this piece finishes the request
module axi_piece_calc
  import axi_sdram_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int BOUNDARY_BYTES = 4096
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [8:0]            remaining,
  input  logic [2:0]            sz,
  input  logic [1:0]            burst,
  output logic [7:0]            axlen,
  output logic [ADDR_WIDTH-1:0] next_addr,
  output logic                  last_piece
);

  localparam int BND_LOG2 = $clog2(BOUNDARY_BYTES);
  // Wide enough for BOUNDARY_BYTES itself and for a 256-beat remainder.
  localparam int CNT_W    = (BND_LOG2 + 1 > 10) ? BND_LOG2 + 1 : 10;

  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] aligned;
  logic [CNT_W-1:0]      off;
  logic [CNT_W-1:0]      beats_to_bnd;
  logic [CNT_W-1:0]      rem_ext;
  logic [CNT_W-1:0]      piece_beats;

  always_comb begin
    size_mask    = (ADDR_WIDTH'(1) << sz) - ADDR_WIDTH'(1);
    aligned      = cur_addr & ~size_mask;
    off          = CNT_W'(aligned & ADDR_WIDTH'(BOUNDARY_BYTES - 1));
    beats_to_bnd = (CNT_W'(BOUNDARY_BYTES) - off) >> sz;
    rem_ext      = CNT_W'(remaining);

    if (burst == BURST_INCR) begin
      piece_beats = (rem_ext < beats_to_bnd) ? rem_ext : beats_to_bnd;
      // Measured from the size-aligned address, so every piece after the
      // first starts exactly on a boundary. Wraps modulo 2^ADDR_WIDTH.
      next_addr   = aligned + (ADDR_WIDTH'(piece_beats) << sz);
    end else begin
      // FIXED / WRAP / reserved go out whole.
      piece_beats = rem_ext;
      next_addr   = cur_addr;
    end

    axlen      = 8'(piece_beats - CNT_W'(1));
    last_piece = (piece_beats == rem_ext);
  end

endmodule

// File: rtl/axi_ax_boundary_splitter.sv
// AXI AR/AW boundary splitter.
// Accepts one packed address request and reissues it as one or more INCR
// sub-bursts, none of which crosses a BOUNDARY_BYTES-aligned address. Every
// issued sub-burst is logged into a piece FIFO as {last_piece, axlen} so the
// data/response path can stitch the pieces back together.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   s_axis_ax_data/valid/ready  request in:
//                            {axsize, axprot, axlock, axlen, axcache, axburst, axaddr}
//   m_axi_ax*                sub-burst out (addr/len per piece, other fields copied,
//                            axsize is the effective size)
//   piece_fifo_wen/din       one write per issued sub-burst
//   piece_fifo_full_n        piece FIFO has room
module axi_ax_boundary_splitter
  import axi_sdram_pkg::*;
#(
  parameter int ADDR_WIDTH         = 32,
  parameter int DATA_WIDTH         = 32,
  parameter int BOUNDARY_BYTES     = 4096,
  parameter int EN_NARROW_TRANSFER = 0
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [ADDR_WIDTH+REQ_EXTRA_W-1:0] s_axis_ax_data,
  input  logic                              s_axis_ax_valid,
  output logic                              s_axis_ax_ready,
  output logic [ADDR_WIDTH-1:0]             m_axi_axaddr,
  output logic [1:0]                        m_axi_axburst,
  output logic [3:0]                        m_axi_axcache,
  output logic [7:0]                        m_axi_axlen,
  output logic                              m_axi_axlock,
  output logic [2:0]                        m_axi_axprot,
  output logic [2:0]                        m_axi_axsize,
  output logic                              m_axi_axvalid,
  input  logic                              m_axi_axready,
  output logic                              piece_fifo_wen,
  output logic [8:0]                        piece_fifo_din,
  input  logic                              piece_fifo_full_n
);

  localparam logic [2:0] MAX_SZ = 3'($clog2(DATA_WIDTH / 8));

  state_t state, next_state;

  // Control (reset)
  logic rst_q;
  logic rdy_q;
  logic vld_q;

  // Request context (no reset)
  logic [ADDR_WIDTH-1:0] cur_addr;
  logic [8:0]            remaining;
  logic [2:0]            sz_q;
  logic [1:0]            burst_q;
  logic [3:0]            cache_q;
  logic                  lock_q;
  logic [2:0]            prot_q;
  logic [ADDR_WIDTH-1:0] next_addr_q;
  logic                  last_q;

  // Request fields
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [1:0]            req_burst;
  logic [3:0]            req_cache;
  logic [7:0]            req_len;
  logic                  req_lock;
  logic [2:0]            req_prot;
  logic [2:0]            req_size;
  logic [2:0]            req_sz_eff;

  logic                  accept;
  logic                  issue_hs;

  logic [7:0]            calc_axlen;
  logic [ADDR_WIDTH-1:0] calc_next;
  logic                  calc_last;

  assign req_addr  = s_axis_ax_data[ADDR_WIDTH-1:0];
  assign req_burst = s_axis_ax_data[ADDR_WIDTH+REQ_BURST_LSB +: 2];
  assign req_cache = s_axis_ax_data[ADDR_WIDTH+REQ_CACHE_LSB +: 4];
  assign req_len   = s_axis_ax_data[ADDR_WIDTH+REQ_LEN_LSB   +: 8];
  assign req_lock  = s_axis_ax_data[ADDR_WIDTH+REQ_LOCK_LSB];
  assign req_prot  = s_axis_ax_data[ADDR_WIDTH+REQ_PROT_LSB  +: 3];
  assign req_size  = s_axis_ax_data[ADDR_WIDTH+REQ_SIZE_LSB  +: 3];

  // Narrow sizes are honoured only when enabled; anything wider than the
  // bus is clamped to the bus width.
  always_comb begin
    req_sz_eff = MAX_SZ;
    if (EN_NARROW_TRANSFER != 0 && req_size < MAX_SZ) req_sz_eff = req_size;
  end

  axi_piece_calc #(
    .ADDR_WIDTH     (ADDR_WIDTH),
    .BOUNDARY_BYTES (BOUNDARY_BYTES)
  ) u_calc (
    .cur_addr   (cur_addr),
    .remaining  (remaining),
    .sz         (sz_q),
    .burst      (burst_q),
    .axlen      (calc_axlen),
    .next_addr  (calc_next),
    .last_piece (calc_last)
  );

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= next_state;
  end

  // FSM next state
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:  if (accept) next_state = ST_CALC;
      ST_CALC:  next_state = ST_ISSUE;
      ST_ISSUE: if (issue_hs) next_state = last_q ? ST_IDLE : ST_CALC;
      default:  next_state = ST_IDLE;
    endcase
  end

  // FSM outputs; handshakes are forced low while rst is high.
  always_comb begin
    s_axis_ax_ready = rdy_q & ~rst;
    m_axi_axvalid   = vld_q & ~rst;
    issue_hs        = m_axi_axvalid & m_axi_axready;
    piece_fifo_wen  = issue_hs;
    accept          = s_axis_ax_ready & s_axis_ax_valid;
  end

  // Registered handshake control. rst_q keeps ready low for one extra cycle
  // after reset is released. Valid is only raised while the FIFO has room,
  // and once raised it stays up until the master takes the piece.
  always_ff @(posedge clk) begin
    rst_q <= rst;
    if (rst) begin
      rdy_q <= 1'b0;
      vld_q <= 1'b0;
    end else begin
      rdy_q <= (next_state == ST_IDLE) && !rst_q;
      case (state)
        ST_CALC:  vld_q <= piece_fifo_full_n;
        ST_ISSUE: begin
          if (issue_hs)    vld_q <= 1'b0;
          else if (!vld_q) vld_q <= piece_fifo_full_n;
        end
        default:  vld_q <= 1'b0;
      endcase
    end
  end

  // Stage boundary: request latch (IDLE) -> piece registers (CALC) -> advance (ISSUE)
  always_ff @(posedge clk) begin
    if (accept) begin
      cur_addr  <= req_addr;
      remaining <= beats_of(req_len);
      sz_q      <= req_sz_eff;
      burst_q   <= req_burst;
      cache_q   <= req_cache;
      lock_q    <= req_lock;
      prot_q    <= req_prot;
    end
    if (state == ST_CALC) begin
      // The first piece keeps the request address as given (possibly
      // unaligned); later pieces start at the boundary from calc_next.
      m_axi_axaddr <= cur_addr;
      m_axi_axlen  <= calc_axlen;
      last_q       <= calc_last;
      next_addr_q  <= calc_next;
    end
    if (state == ST_ISSUE && issue_hs) begin
      cur_addr  <= next_addr_q;
      remaining <= remaining - beats_of(m_axi_axlen);
    end
  end

  assign m_axi_axburst  = burst_q;
  assign m_axi_axcache  = cache_q;
  assign m_axi_axlock   = lock_q;
  assign m_axi_axprot   = prot_q;
  assign m_axi_axsize   = sz_q;
  assign piece_fifo_din = {last_q, m_axi_axlen};

endmodule

// File: doc/axi_ax_boundary_splitter.md
Name: axi_ax_boundary_splitter

Overview:
- Parametrised successor of the AXI AR/AW boundary protector: takes one AXI address request and reissues it as N ≥ 1 INCR sub-bursts, none of which crosses a BOUNDARY_BYTES-aligned address.
- Supports configurable address and data width, any power-of-two boundary, and multi-way splits; FIXED/WRAP requests pass through unsplit.
- Sits between an AXI slave address channel and a downstream memory controller (e.g. SDRAM), and logs each sub-burst into a piece FIFO so the data/response path can merge them.

Parameters:
ADDR_WIDTH, 32, address width in bits (≥ 16)
DATA_WIDTH, 32, data bus width in bits (8..1024, power of two)
BOUNDARY_BYTES, 4096, protected boundary in bytes (power of two, ≥ DATA_WIDTH/8, ≤ 4096)
EN_NARROW_TRANSFER, 0, 1 = honour axsize; 0 = force axsize to log2(DATA_WIDTH/8)

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active high
s_axis_ax_data  in  ADDR_WIDTH+21  {axsize[3], axprot[3], axlock, axlen[8], axcache[4], axburst[2], axaddr[ADDR_WIDTH]}
s_axis_ax_valid  in  1  slave request valid
s_axis_ax_ready  out  1  slave request accepted
m_axi_axaddr  out  ADDR_WIDTH  sub-burst start address
m_axi_axburst  out  2  copied from request
m_axi_axcache  out  4  copied
m_axi_axlen  out  8  sub-burst beats-1
m_axi_axlock  out  1  copied
m_axi_axprot  out  3  copied
m_axi_axsize  out  3  effective size
m_axi_axvalid  out  1  master valid
m_axi_axready  in  1  master ready
piece_fifo_wen  out  1  one write per issued sub-burst
piece_fifo_din  out  9  {last_piece, axlen}
piece_fifo_full_n  in  1  piece FIFO not full

Behaviour:
- One clock; reset is synchronous and active-high. While rst = 1 and in the cycle after: s_axis_ax_ready = 0, m_axi_axvalid = 0, piece_fifo_wen = 0, state = IDLE. Reset during CALC/ISSUE abandons the request; no partial pieces are completed.
- Effective size sz = EN_NARROW_TRANSFER ? axsize : log2(DATA_WIDTH/8). An axsize above log2(DATA_WIDTH/8) is clamped to it.
- FSM:
  - IDLE: s_axis_ax_ready = 1. On valid & ready: latch all fields, cur_addr = axaddr, remaining = axlen+1 (9-bit); go to CALC.
  - CALC (1 cycle): compute the piece and register it into the m_axi_* outputs; go to ISSUE.
  - ISSUE: m_axi_axvalid = piece_fifo_full_n (only rises when FIFO has room; once high it is held, with all fields stable, until m_axi_axready). On handshake: piece_fifo_wen = 1 that cycle, remaining -= piece_beats, cur_addr = next_addr. Then go to IDLE if last_piece, else CALC.
- Piece arithmetic (INCR):
  - aligned = cur_addr & ~((1<<sz)-1)
  - off = aligned & (BOUNDARY_BYTES-1)
  - beats_to_bnd = (BOUNDARY_BYTES - off) >> sz
  - piece_beats = min(remaining, beats_to_bnd); axlen = piece_beats-1
  - next_addr = aligned + (piece_beats << sz), i.e. always boundary-aligned
  - last_piece = (piece_beats == remaining)
  - First piece keeps the original (possibly unaligned) address; later pieces are boundary-aligned.
- FIXED/WRAP/reserved burst: a single piece with the request address and axlen, last_piece = 1.
- Address arithmetic wraps modulo 2^ADDR_WIDTH.
- Latency: slave handshake at cycle t gives m_axi_axvalid at t+2 at the earliest. Throughput is at best 2 cycles per piece. The next slave request is accepted the cycle after the last piece's handshake.
- piece_fifo_wen equals m_axi_axvalid & m_axi_axready exactly.

Decomposition:
- Shared package axi_sdram_pkg: AXI burst encodings (FIXED/INCR/WRAP), the request bit-field offsets for s_axis_ax_data, and the FSM state constants.
- One sub-module, axi_piece_calc: purely combinational, computing (cur_addr, remaining, sz, burst) -> (axlen, next_addr, last_piece), parametrised by ADDR_WIDTH/BOUNDARY_BYTES.

Test Plan:
- Defaults. INCR addr 0x0100, len 15, size 2 -> one piece: addr 0x0100, len 15; FIFO din {1,15}.
- Defaults. INCR addr 0x0FC0, len 31, size 2 -> two pieces: {0x0FC0, len 15, last 0} then {0x1000, len 15, last 1}.
- DATA_WIDTH=64, BOUNDARY_BYTES=256. INCR addr 0x00F0, len 63, size 3 -> three pieces: {0x00F0, 1, 0}, {0x0100, 31, 0}, {0x0200, 29, 1}.
- Defaults, EN_NARROW_TRANSFER=1. Unaligned INCR addr 0x0FFE, len 3, size 2 -> {0x0FFE, 0, 0}, {0x1000, 2, 1}. Also FIXED addr 0x0FFC, len 7 -> single piece {0x0FFC, 7, 1}.
- Backpressure:
  - piece_fifo_full_n = 0 for 5 cycles -> m_axi_axvalid stays 0; it asserts 1 cycle after full_n rises.
  - m_axi_axready = 0 for 10 cycles -> valid and all fields held stable, exactly one FIFO write.
- Assert rst during ISSUE of the 2nd piece of the 3-piece case -> next cycle valid = 0, ready = 0, no wen; after release, a new request is processed correctly.
